// File: rtl/grid_pkg.sv
// Shared constants and types for the column-store renderer: geometry, cell codes,
// colours and FSM state encodings.
package grid_pkg;
    localparam int NUM_COLS = 16;
    localparam int NUM_ROWS = 14;
    localparam int CELL_PX  = 8;
    localparam int CODE_W   = 2;
    localparam int WORD_W   = CODE_W * NUM_ROWS;
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam int CELL_W   = $clog2(NUM_ROWS);
    localparam int PX_W     = $clog2(CELL_PX);

    typedef enum logic [CODE_W-1:0] {
        EMPTY = 2'b00,
        MEAT  = 2'b01,
        GREEN = 2'b10,
        WHITE = 2'b11
    } cell_code_t;

    localparam logic [2:0] COLOUR_EMPTY = 3'b000;
    localparam logic [2:0] COLOUR_MEAT  = 3'b100;
    localparam logic [2:0] COLOUR_GREEN = 3'b010;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_DRAW  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
endpackage

// File: rtl/cell_colour_lut.sv
// Combinational map from a 2-bit cell code to a 3-bit {R,G,B} colour.
module cell_colour_lut
    import grid_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [2:0]        colour
);
    always_comb begin
        colour = COLOUR_EMPTY;
        case (cell_code_t'(code))
            EMPTY:   colour = COLOUR_EMPTY;
            MEAT:    colour = COLOUR_MEAT;
            GREEN:   colour = COLOUR_GREEN;
            WHITE:   colour = COLOUR_WHITE;
            default: colour = COLOUR_EMPTY;
        endcase
    end
endmodule

// File: rtl/grid_renderer.sv
// Frame scan-out of the column store as 8x8 cell blocks, one pixel per cycle.
// Define GRID_SKIP_UNCHANGED_EN to skip columns whose word matches the last drawn copy.
module grid_renderer
    import grid_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rd_addr,
    input  logic [27:0] rd_data,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);
    logic [2:0]        state_reg;
    logic [COL_W-1:0]  col_reg;
    logic [CELL_W-1:0] cell_reg;
    logic [PX_W-1:0]   py_reg;
    logic [PX_W-1:0]   px_reg;
    logic [WORD_W-1:0] word_reg;
    logic [COL_W-1:0]  rd_addr_reg;
    logic [2:0]        colour_reg;
    logic              plot_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              last_px, last_py, last_cell, last_col;
    logic              cell_adv, col_end, skip_col, advance_col;
    logic [CELL_W-1:0] cell_sel;
    logic [CELL_W:0]   code_idx;
    logic [CODE_W-1:0] code;
    logic [2:0]        lut_colour;

    assign last_px   = (px_reg == PX_W'(CELL_PX - 1));
    assign last_py   = (py_reg == PX_W'(CELL_PX - 1));
    assign last_cell = (cell_reg == CELL_W'(NUM_ROWS - 1));
    assign last_col  = (col_reg == COL_W'(NUM_COLS - 1));
    assign cell_adv  = last_px && last_py;
    assign col_end   = cell_adv && last_cell;

    // Colour is looked up for the pixel about to be shown, so it lands in the
    // same register stage as x/y/plot.
    assign cell_sel = (cell_adv && !last_cell) ? cell_reg + CELL_W'(1) : cell_reg;
    assign code_idx = {cell_sel, 1'b0};
    assign code     = (state_reg == ST_LATCH) ? rd_data[CODE_W-1:0]
                                              : word_reg[code_idx +: CODE_W];

    cell_colour_lut u_lut (
        .code   (code),
        .colour (lut_colour)
    );

`ifdef GRID_SKIP_UNCHANGED_EN
    logic [WORD_W-1:0]   shadow_mem [NUM_COLS];
    logic [WORD_W-1:0]   shadow_rd_reg;
    logic [NUM_COLS-1:0] valid_reg;
    logic                shadow_wr;

    assign shadow_wr = (state_reg == ST_DRAW) && col_end;

    // col_reg is stable from FETCH onward, so the registered read is ready by LATCH.
    always_ff @(posedge clk) begin
        if (shadow_wr)
            shadow_mem[col_reg] <= word_reg;
        shadow_rd_reg <= shadow_mem[col_reg];
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            valid_reg <= '0;
        else if (shadow_wr)
            valid_reg[col_reg] <= 1'b1;
    end

    assign skip_col = valid_reg[col_reg] && (rd_data == shadow_rd_reg);
`else
    assign skip_col = 1'b0;
`endif

    assign advance_col = ((state_reg == ST_LATCH) && skip_col) ||
                         ((state_reg == ST_DRAW) && col_end);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            col_reg     <= '0;
            cell_reg    <= '0;
            py_reg      <= '0;
            px_reg      <= '0;
            word_reg    <= '0;
            rd_addr_reg <= '0;
            colour_reg  <= '0;
            plot_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_FETCH;
                        col_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    rd_addr_reg <= col_reg;
                    state_reg   <= ST_WAIT;
                end
                ST_WAIT: state_reg <= ST_LATCH;
                ST_LATCH: begin
                    word_reg   <= rd_data;
                    cell_reg   <= '0;
                    py_reg     <= '0;
                    px_reg     <= '0;
                    colour_reg <= lut_colour;
                    plot_reg   <= !skip_col;
                    if (!skip_col)
                        state_reg <= ST_DRAW;
                end
                ST_DRAW: begin
                    px_reg <= px_reg + PX_W'(1);
                    if (last_px)
                        py_reg <= py_reg + PX_W'(1);
                    if (cell_adv && !last_cell)
                        cell_reg <= cell_reg + CELL_W'(1);
                    colour_reg <= lut_colour;
                    plot_reg   <= !col_end;
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase

            if (advance_col) begin
                if (last_col) begin
                    state_reg <= ST_DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end else begin
                    col_reg   <= col_reg + COL_W'(1);
                    state_reg <= ST_FETCH;
                end
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_addr = 4'(rd_addr_reg);
    assign x       = 8'({col_reg, px_reg});
    assign y       = 7'({cell_reg, py_reg});
    assign colour  = colour_reg;
    assign plot    = plot_reg;
endmodule

// File: tb/tb_grid_renderer.sv
// Bench for grid_renderer: table of frame scenarios, random frames, reset and busy corners.
`timescale 1ns/1ps
module tb_grid_renderer;
    localparam int PIX_PER_COL = 896;

    logic        clk, resetn, start;
    logic        busy, done, plot;
    logic [3:0]  rd_addr;
    logic [27:0] rd_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;

    logic [27:0] mem [16];
    logic [27:0] snap [16];
    logic [27:0] model_shadow [16];
    bit          model_valid [16];
    int          draw_cols [16];
    int          n_draw;

    int total = 0;
    int bad   = 0;

    bit       mon_on;
    int       plot_cnt, lit_cnt, lit_bad, pix_err, done_cnt, last_n;
    int       lx_min, lx_max, ly_min, ly_max, px_min, px_max;
    logic [2:0] exp_lit_col;
    string    first_err;

    typedef struct {
        int          col;
        logic [27:0] word;
        int          busy_at;
        int          mod_at;
        bit          start_done;
        int          lit;
        int          xmin, xmax, ymin, ymax;
        logic [2:0]  lit_col;
    } vec_t;
    vec_t vecs [3];

    grid_renderer dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .x(x), .y(y),
        .colour(colour), .plot(plot)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Registered-address store RAM.
    always @(posedge clk) rd_data <= mem[rd_addr];

    function automatic logic [2:0] ref_colour(input logic [27:0] word, input int k);
        int code;
        code = int'((word >> (2 * k)) & 28'h3);
        case (code)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Plot n of a frame is pixel (n mod 8, row) of cell ((n mod 896)/64) in the (n/896)-th drawn column.
    always @(negedge clk) begin : monitor
        int idx, c, r, k, ex, ey;
        logic [2:0] ec;
        if (mon_on && plot) begin
            idx = plot_cnt / PIX_PER_COL;
            if (idx < n_draw) begin
                c  = draw_cols[idx];
                r  = plot_cnt % PIX_PER_COL;
                k  = r / 64;
                ex = c * 8 + r % 8;
                ey = k * 8 + (r % 64) / 8;
                ec = ref_colour(snap[c], k);
                if (int'(x) != ex || int'(y) != ey || colour != ec) begin
                    if (pix_err == 0)
                        first_err = $sformatf("plot %0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                                              plot_cnt, x, y, colour, ex, ey, ec);
                    pix_err++;
                end
            end else begin
                if (pix_err == 0)
                    first_err = $sformatf("extra plot %0d at x=%0d y=%0d", plot_cnt, x, y);
                pix_err++;
            end
            if (int'(x) < px_min) px_min = int'(x);
            if (int'(x) > px_max) px_max = int'(x);
            if (colour != 3'b000) begin
                lit_cnt++;
                if (colour != exp_lit_col) lit_bad++;
                if (int'(x) < lx_min) lx_min = int'(x);
                if (int'(x) > lx_max) lx_max = int'(x);
                if (int'(y) < ly_min) ly_min = int'(y);
                if (int'(y) > ly_max) ly_max = int'(y);
            end
            plot_cnt++;
        end
        if (mon_on && done) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s = %0d", nm, act);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        start  = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int c = 0; c < 16; c++) model_valid[c] = 1'b0;
    endtask

    task automatic do_frame(input string nm, input int busy_at, input int mod_at,
                            input int reset_at, input bit start_done);
        int  n, exp_plots, exp_cycles;
        bit  finished, aborted;
        n_draw = 0;
        for (int c = 0; c < 16; c++) begin
            snap[c] = mem[c];
`ifdef GRID_SKIP_UNCHANGED_EN
            if (!(model_valid[c] && model_shadow[c] == snap[c])) begin
                draw_cols[n_draw] = c;
                n_draw++;
            end
`else
            draw_cols[n_draw] = c;
            n_draw++;
`endif
        end
        exp_plots  = PIX_PER_COL * n_draw;
        exp_cycles = 48 + PIX_PER_COL * n_draw;
        plot_cnt = 0; lit_cnt = 0; lit_bad = 0; pix_err = 0; done_cnt = 0;
        lx_min = 999; lx_max = -1; ly_min = 999; ly_max = -1; px_min = 999; px_max = -1;
        first_err = "";
        mon_on = 1'b1;

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0; finished = 1'b0; aborted = 1'b0;
        while (!finished && n < 20000) begin
            @(posedge clk); n++; #1;
            start = (n == busy_at);
            if (n == 1) chk({nm, " busy_rise"}, int'(busy), 1);
            if (n == mod_at) mem[draw_cols[0]] = ~mem[draw_cols[0]];
            if (n == reset_at) begin
                resetn  = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (done) finished = 1'b1;
        end
        last_n = n;

        if (aborted) begin
            @(posedge clk); #1;
            chk({nm, " rst_plot"}, int'(plot), 0);
            chk({nm, " rst_busy"}, int'(busy), 0);
            resetn = 1'b1;
            repeat (10) @(posedge clk);
            #1 chk({nm, " rst_no_done"}, done_cnt, 0);
            mon_on = 1'b0;
            for (int c = 0; c < 16; c++) model_valid[c] = 1'b0;
        end else begin
            chk({nm, " done_seen"}, int'(finished), 1);
            if (start_done) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                repeat (3) @(posedge clk);
                #1 chk({nm, " start_at_done_ignored"}, int'(busy), 0);
            end else begin
                repeat (2) @(posedge clk);
                #1;
            end
            mon_on = 1'b0;
            chk({nm, " cycles"}, n, exp_cycles);
            chk({nm, " plots"}, plot_cnt, exp_plots);
            chk({nm, " done_count"}, done_cnt, 1);
            total++;
            if (pix_err != 0) begin
                bad++;
                $display("FAIL %s pixels: %0d wrong, first: %s", nm, pix_err, first_err);
            end else begin
                $display("ok   %s pixels all match model", nm);
            end
            for (int i = 0; i < n_draw; i++) begin
                model_valid[draw_cols[i]]  = 1'b1;
                model_shadow[draw_cols[i]] = snap[draw_cols[i]];
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mon_on = 1'b0;
        n_draw = 0;
        exp_lit_col = 3'b000;
        for (int c = 0; c < 16; c++) begin
            mem[c] = '0;
            model_valid[c] = 1'b0;
            model_shadow[c] = '0;
        end

        // Reset held with start asserted.
        resetn = 1'b0;
        start  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset plot", int'(plot), 0);
        chk("reset done", int'(done), 0);
        chk("reset x", int'(x), 0);
        chk("reset y", int'(y), 0);
        chk("reset colour", int'(colour), 0);
        chk("reset rd_addr", int'(rd_addr), 0);
        start  = 1'b0;
        resetn = 1'b1;

        vecs[0] = '{2,  28'h0000001, 500, -1,  1'b1, 64,  16,  23,  0,   7,   3'b100};
        vecs[1] = '{15, 28'h8000000, -1,  500, 1'b0, 64,  120, 127, 104, 111, 3'b010};
        vecs[2] = '{0,  28'hFFFFFFF, -1,  -1,  1'b0, 896, 0,   7,   0,   111, 3'b111};

        for (int i = 0; i < 3; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_reset();
            for (int c = 0; c < 16; c++) mem[c] = '0;
            mem[vecs[i].col] = vecs[i].word;
            exp_lit_col = vecs[i].lit_col;
            do_frame(nm, vecs[i].busy_at, vecs[i].mod_at, -1, vecs[i].start_done);
            chk({nm, " lit_count"}, lit_cnt, vecs[i].lit);
            chk({nm, " lit_colour_bad"}, lit_bad, 0);
            chk({nm, " lit_xmin"}, lx_min, vecs[i].xmin);
            chk({nm, " lit_xmax"}, lx_max, vecs[i].xmax);
            chk({nm, " lit_ymin"}, ly_min, vecs[i].ymin);
            chk({nm, " lit_ymax"}, ly_max, vecs[i].ymax);
            chk({nm, " max_x"}, int'(px_max <= 127), 1);
        end

        // Random store contents: aborted frame, then a clean full frame.
        for (int c = 0; c < 16; c++) mem[c] = 28'($urandom());
        exp_lit_col = 3'b000;
        do_frame("midrst", -1, -1, 5000, 1'b0);
        do_frame("rand_after_rst", -1, -1, -1, 1'b0);

`ifdef GRID_SKIP_UNCHANGED_EN
        do_frame("unchanged", -1, -1, -1, 1'b0);
        chk("unchanged zero_plots", plot_cnt, 0);
        chk("unchanged 48_cycles", last_n, 48);
        mem[7] = mem[7] ^ 28'h0000004;
        do_frame("col7_changed", -1, -1, -1, 1'b0);
        chk("col7 plots", plot_cnt, 896);
        chk("col7 xmin", px_min, 56);
        chk("col7 xmax", px_max, 63);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
